array_write_arbiter: RTL and testbench
======================================

Name: array_write_arbiter

Overview:
- Owns the single write port of one param_array instance and shares it between two write requesters (e.g. I-side and D-side LRU/valid updates).
- Uses valid/ready handshakes with round-robin arbitration.
- Runs a flush sweep that writes zero to every set.
- Forwards same-cycle writes onto the read path, because the array has no internal write-to-read bypass.

Parameters:
- width, 1, bits per array entry
- Sets, 8, number of sets (need not be a power of two)
- Set_index, $clog2(Sets)-1, MSB of set index

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- req0_valid  in  1  requester 0 write request
- req0_ready  out  1  requester 0 grant; handshake when valid & ready
- req0_index  in  Set_index+1  requester 0 target set
- req0_data  in  width  requester 0 write data
- req1_valid / req1_ready / req1_index / req1_data  same as requester 0, for requester 1
- flush_req  in  1  one-cycle request to clear all sets
- flush_busy  out  1  sweep in progress
- flush_done  out  1  one-cycle pulse on the last sweep write
- rd_index  in  Set_index+1  read set from consumer
- rd_data  out  width  read data with forwarding
- arr_load  out  1  to param_array load
- arr_windex  out  Set_index+1  to param_array windex
- arr_datain  out  width  to param_array datain
- arr_rindex  out  Set_index+1  to param_array rindex
- arr_dataout  in  width  from param_array dataout

Behaviour:
- States: RUN, FLUSH. Reset state is RUN.
- Registered state at reset: sweep counter 0, round-robin pointer 0 (req0 preferred), flush_done 0.
- While rst=0, all outputs are 0, except rd_data/arr_rindex, which stay combinational.

RUN:
- If exactly one request is valid, it is granted: its readyN=1 combinationally in the same cycle.
- If both are valid, the grant goes to the requester named by the pointer.
- After any grant, the pointer moves to the other requester.
- At most one grant per cycle. An ungranted requester must hold valid, index and data stable.
- On grant: arr_load=1, and arr_windex/arr_datain come from the granted requester in the same cycle.
- The array updates at the next edge, so the write is visible from arr_dataout one cycle later.
- No valid request: arr_load=0. Ready is never asserted without the matching valid.
- Both requesters targeting the same index: serialized in round-robin order; the second write wins.

Flush:
- flush_req=1 in RUN: any grant in that same cycle still completes; FLUSH is entered at the next edge.
- FLUSH lasts exactly Sets cycles. Each cycle: arr_load=1, arr_windex=counter, arr_datain='0, counter increments.
- During FLUSH: req0_ready=req1_ready=0 and flush_busy=1.
- flush_done=1 in the cycle where counter==Sets-1, which is the last write.
- Next state is RUN with the counter cleared. The first grant is possible in the cycle after flush_done.
- flush_req during FLUSH is ignored and does not restart the sweep.
- The pointer is not changed by a flush.

Read path:
- arr_rindex = rd_index.
- rd_data = arr_datain when arr_load && arr_windex==rd_index, otherwise arr_dataout.
- Forwarding applies to both granted writes and flush writes.

Reset mid-operation:
- Asynchronous rst=0 aborts a sweep immediately: state RUN, counter 0, pointer 0, arr_load 0.
- Sets already cleared stay cleared; the remaining sets are not guaranteed cleared.

Widths:
- The counter is Set_index+1 bits.
- Sets non-power-of-two: the counter never exceeds Sets-1.

Decomposition:
- Package arb_pkg: state enum (RUN, FLUSH).
- Sub-module rr_arb2: two-input round-robin arbiter with a registered pointer.
  - Inputs: two valids, an enable, and an async active-low reset.
  - Output: one-hot grant.
- The top level holds the FSM, sweep counter, write mux and forwarding mux.

Test Plan:
- Reset, then req0 only: index 3, data 1 -> req0_ready=1 same cycle, arr_load=1, arr_windex=3; after 1 cycle, reading index 3 returns 1.
- Both valid each cycle: req0 idx 2 data 1, req1 idx 5 data 1 -> grants alternate 0,1,0,1…; no cycle with both ready; pointer alternates.
- Forwarding: req1 writes idx 4 data 1 while rd_index=4 and the array holds 0 -> rd_data=1 in the same cycle; rd_index=5 -> arr_dataout.
- Flush with Sets=8 after writing 1 to all sets:
  - flush_req together with req0 valid: the req0 grant completes; then 8 cycles of flush_busy=1 with windex 0..7 and data 0.
  - flush_done is high only on windex=7.
  - A request held valid during the sweep gets no ready until the following cycle; every set then reads 0.
- flush_req during FLUSH at counter 3 -> ignored; flush_done still occurs at counter 7, no restart.
- rst=0 asynchronously at counter 5 -> arr_load=0 and flush_busy=0 immediately; after release, state RUN and req0 preferred; Sets=6 variant completes in exactly 6 cycles.

Source files
------------

// File: rtl/array_write_arbiter_pkg.sv
// Shared types for the array write arbiter: top-level sweep FSM states.
package arb_pkg;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } arb_state_e;

endpackage

// File: rtl/array_write_arbiter_if.sv
// Bundles the requester, flush, read and param_array-facing signals of one arbiter.
interface array_write_arbiter_if #(
   parameter int width     = 1,
   parameter int Sets      = 8,
   parameter int Set_index = $clog2(Sets) - 1
);

   logic                 req0_valid;
   logic                 req0_ready;
   logic [Set_index:0]   req0_index;
   logic [width-1:0]     req0_data;
   logic                 req1_valid;
   logic                 req1_ready;
   logic [Set_index:0]   req1_index;
   logic [width-1:0]     req1_data;
   logic                 flush_req;
   logic                 flush_busy;
   logic                 flush_done;
   logic [Set_index:0]   rd_index;
   logic [width-1:0]     rd_data;
   logic                 arr_load;
   logic [Set_index:0]   arr_windex;
   logic [width-1:0]     arr_datain;
   logic [Set_index:0]   arr_rindex;
   logic [width-1:0]     arr_dataout;

   modport master (
      output req0_valid, req0_index, req0_data,
      input  req0_ready,
      output req1_valid, req1_index, req1_data,
      input  req1_ready,
      output flush_req,
      input  flush_busy, flush_done,
      output rd_index,
      input  rd_data,
      input  arr_load, arr_windex, arr_datain, arr_rindex,
      output arr_dataout
   );

   modport slave (
      input  req0_valid, req0_index, req0_data,
      output req0_ready,
      input  req1_valid, req1_index, req1_data,
      output req1_ready,
      input  flush_req,
      output flush_busy, flush_done,
      input  rd_index,
      output rd_data,
      output arr_load, arr_windex, arr_datain, arr_rindex,
      input  arr_dataout
   );

endinterface

// File: rtl/array_write_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the requester that wins a tie
// and flips to the other side after every grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic [1:0] valid_i,
   output logic [1:0] grant_o
);

   logic ptr_q, ptr_d;

   always_comb begin
      grant_o = 2'b00;
      if (en_i) begin
         if (valid_i == 2'b11) grant_o = ptr_q ? 2'b10 : 2'b01;
         else                  grant_o = valid_i;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant_o[0])      ptr_d = 1'b1;
      else if (grant_o[1]) ptr_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= 1'b0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/array_write_arbiter.sv
// Owns the param_array write port: round-robin between two requesters, a zeroing
// flush sweep, and same-cycle write-to-read forwarding.
module array_write_arbiter
   import arb_pkg::*;
#(
   parameter int width     = 1,
   parameter int Sets      = 8,
   parameter int Set_index = $clog2(Sets) - 1
) (
   input logic                 clk,
   input logic                 rst,
   array_write_arbiter_if.slave bus
);

   localparam int CW = Set_index + 1;
   localparam logic [Set_index:0] LAST = CW'(Sets - 1);

   arb_state_e          state_q, state_d;
   logic [Set_index:0]  cnt_q, cnt_d;
   logic [1:0]          grant;
   logic                busy;
   logic                load;
   logic [Set_index:0]  windex;
   logic [width-1:0]    datain;

   // Outputs are gated by rst so they read zero for the whole time reset is held.
   assign busy = rst && (state_q == FLUSH);

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst),
      .en_i    (rst && (state_q == RUN)),
      .valid_i ({bus.req1_valid, bus.req0_valid}),
      .grant_o (grant)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (bus.flush_req) begin
               state_d = FLUSH;
               cnt_d   = '0;
            end
         end
         FLUSH: begin
            if (cnt_q == LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      load   = 1'b0;
      windex = '0;
      datain = '0;
      if (busy) begin
         load   = 1'b1;
         windex = cnt_q;
      end else if (grant[0]) begin
         load   = 1'b1;
         windex = bus.req0_index;
         datain = bus.req0_data;
      end else if (grant[1]) begin
         load   = 1'b1;
         windex = bus.req1_index;
         datain = bus.req1_data;
      end
   end

   assign bus.req0_ready = grant[0];
   assign bus.req1_ready = grant[1];
   assign bus.flush_busy = busy;
   assign bus.flush_done = busy && (cnt_q == LAST);
   assign bus.arr_load   = load;
   assign bus.arr_windex = windex;
   assign bus.arr_datain = datain;
   assign bus.arr_rindex = bus.rd_index;
   assign bus.rd_data    = (load && (windex == bus.rd_index)) ? datain : bus.arr_dataout;

endmodule

// File: tb/tb_array_write_arbiter.sv
// Bench for array_write_arbiter: behavioural param_array models, a write scoreboard
// fed by the scenario tasks, and inline per-scenario checks.
module tb_array_write_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   array_write_arbiter_if #(.width(1), .Sets(8)) bus ();
   array_write_arbiter_if #(.width(1), .Sets(6)) bus6 ();

   array_write_arbiter #(.width(1), .Sets(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
   array_write_arbiter #(.width(1), .Sets(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

   logic mem8 [8] = '{default: 1'b0};
   logic mem6 [8] = '{default: 1'b0};

   always @(posedge clk) if (bus.arr_load)  mem8[bus.arr_windex]  <= bus.arr_datain;
   always @(posedge clk) if (bus6.arr_load) mem6[bus6.arr_windex] <= bus6.arr_datain;
   assign bus.arr_dataout  = mem8[bus.arr_rindex];
   assign bus6.arr_dataout = mem6[bus6.arr_rindex];

   typedef struct packed {
      logic [2:0] idx;
      logic       d;
   } wr_t;

   wr_t exp_q [$];
   wr_t sb_e;
   int  tests = 0;
   int  fails = 0;

   // Scoreboard: every array write must match the next expected write in order.
   always @(negedge clk) begin
      if (rst && bus.arr_load) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected_write got idx=%0d data=%0b exp=none", bus.arr_windex, bus.arr_datain);
         end else begin
            sb_e = exp_q.pop_front();
            if ({bus.arr_windex, bus.arr_datain} !== {sb_e.idx, sb_e.d}) begin
               fails++;
               $display("FAIL sb_write got idx=%0d data=%0b exp idx=%0d data=%0b",
                        bus.arr_windex, bus.arr_datain, sb_e.idx, sb_e.d);
            end
         end
      end
   end

   task automatic idle();
      bus.req0_valid = 1'b0; bus.req0_index = '0; bus.req0_data = '0;
      bus.req1_valid = 1'b0; bus.req1_index = '0; bus.req1_data = '0;
      bus.flush_req  = 1'b0; bus.rd_index   = '0;
   endtask

   task automatic idle6();
      bus6.req0_valid = 1'b0; bus6.req0_index = '0; bus6.req0_data = '0;
      bus6.req1_valid = 1'b0; bus6.req1_index = '0; bus6.req1_data = '0;
      bus6.flush_req  = 1'b0; bus6.rd_index   = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_index = 3'd1; bus.req0_data = 1'b1;
      bus.req1_valid = 1'b1; bus.req1_index = 3'd6; bus.req1_data = 1'b1;
      bus.flush_req  = 1'b1; bus.rd_index   = 3'd2;
      @(negedge clk);
      tests++;
      if ({bus.req0_ready, bus.req1_ready, bus.arr_load, bus.flush_busy, bus.flush_done} !== 5'b0) begin
         fails++;
         $display("FAIL reset_ctrl got=%b exp=00000",
                  {bus.req0_ready, bus.req1_ready, bus.arr_load, bus.flush_busy, bus.flush_done});
      end
      tests++;
      if ({bus.arr_windex, bus.arr_datain} !== 4'b0) begin
         fails++;
         $display("FAIL reset_bus got idx=%0d data=%0b exp idx=0 data=0", bus.arr_windex, bus.arr_datain);
      end
      tests++;
      if (bus.arr_rindex !== 3'd2) begin
         fails++;
         $display("FAIL reset_rindex got=%0d exp=2", bus.arr_rindex);
      end
      next_cycle();
      idle();
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if ({bus.flush_busy, bus.arr_load} !== 2'b00) begin
         fails++;
         $display("FAIL reset_release got=%b exp=00", {bus.flush_busy, bus.arr_load});
      end
      next_cycle();
   endtask

   task automatic test_single();
      bus.req0_valid = 1'b1; bus.req0_index = 3'd3; bus.req0_data = 1'b1;
      exp_q.push_back(wr_t'{idx: 3'd3, d: 1'b1});
      @(negedge clk);
      tests++;
      if ({bus.req0_ready, bus.req1_ready, bus.arr_load} !== 3'b101) begin
         fails++;
         $display("FAIL single_grant got=%b exp=101", {bus.req0_ready, bus.req1_ready, bus.arr_load});
      end
      next_cycle();
      idle();
      bus.rd_index = 3'd3;
      @(negedge clk);
      tests++;
      if ({bus.arr_load, bus.rd_data} !== 2'b01) begin
         fails++;
         $display("FAIL single_readback got load,data=%b exp=01", {bus.arr_load, bus.rd_data});
      end
      next_cycle();
   endtask

   task automatic test_round_robin();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_index = 3'd2; bus.req0_data = 1'b1;
      bus.req1_valid = 1'b1; bus.req1_index = 3'd5; bus.req1_data = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) exp_q.push_back(wr_t'{idx: 3'd2, d: 1'b1});
         else            exp_q.push_back(wr_t'{idx: 3'd5, d: 1'b1});
         @(negedge clk);
         tests++;
         if ({bus.req1_ready, bus.req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
            fails++;
            $display("FAIL rr_grant cycle=%0d got ready1,0=%b exp=%b", i,
                     {bus.req1_ready, bus.req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
         end
         next_cycle();
      end
      idle();
   endtask

   task automatic test_forward();
      bus.req1_valid = 1'b1; bus.req1_index = 3'd4; bus.req1_data = 1'b1;
      bus.rd_index   = 3'd4;
      exp_q.push_back(wr_t'{idx: 3'd4, d: 1'b1});
      @(negedge clk);
      tests++;
      if ({bus.req1_ready, bus.arr_dataout, bus.rd_data} !== 3'b101) begin
         fails++;
         $display("FAIL fwd_hit got ready1,dataout,rd_data=%b exp=101",
                  {bus.req1_ready, bus.arr_dataout, bus.rd_data});
      end
      bus.rd_index = 3'd6;
      #1;
      tests++;
      if (bus.rd_data !== 1'b0) begin
         fails++;
         $display("FAIL fwd_miss got=%b exp=0", bus.rd_data);
      end
      next_cycle();
      idle();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 8; i++) begin
         bus.req0_valid = 1'b1; bus.req0_index = 3'(i); bus.req0_data = 1'b1;
         exp_q.push_back(wr_t'{idx: 3'(i), d: 1'b1});
         @(negedge clk);
         tests++;
         if (bus.req0_ready !== 1'b1) begin
            fails++;
            $display("FAIL fill_grant set=%0d got=%b exp=1", i, bus.req0_ready);
         end
         next_cycle();
      end
      bus.flush_req  = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_index = 3'd1; bus.req0_data = 1'b1;
      exp_q.push_back(wr_t'{idx: 3'd1, d: 1'b1});
      @(negedge clk);
      tests++;
      if ({bus.req0_ready, bus.flush_busy} !== 2'b10) begin
         fails++;
         $display("FAIL flush_entry_grant got ready0,busy=%b exp=10", {bus.req0_ready, bus.flush_busy});
      end
      next_cycle();
      bus.flush_req  = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_index = 3'd7; bus.req1_data = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(wr_t'{idx: 3'(i), d: 1'b0});
         @(negedge clk);
         tests++;
         if ({bus.flush_busy, bus.req0_ready, bus.req1_ready, bus.flush_done} !== {3'b100, i == 7}) begin
            fails++;
            $display("FAIL flush_sweep cnt=%0d got busy,r0,r1,done=%b exp=%b", i,
                     {bus.flush_busy, bus.req0_ready, bus.req1_ready, bus.flush_done}, {3'b100, i == 7});
         end
         next_cycle();
      end
      exp_q.push_back(wr_t'{idx: 3'd7, d: 1'b0});
      @(negedge clk);
      tests++;
      if ({bus.flush_busy, bus.req1_ready} !== 2'b01) begin
         fails++;
         $display("FAIL flush_exit_grant got busy,ready1=%b exp=01", {bus.flush_busy, bus.req1_ready});
      end
      next_cycle();
      idle();
      for (int i = 0; i < 8; i++) begin
         bus.rd_index = 3'(i);
         #1;
         tests++;
         if (bus.rd_data !== 1'b0) begin
            fails++;
            $display("FAIL flush_cleared set=%0d got=%b exp=0", i, bus.rd_data);
         end
      end
      next_cycle();
   endtask

   task automatic test_flush_ignore();
      bus.flush_req = 1'b1;
      next_cycle();
      for (int i = 0; i < 8; i++) begin
         bus.flush_req = (i == 3);
         exp_q.push_back(wr_t'{idx: 3'(i), d: 1'b0});
         @(negedge clk);
         tests++;
         if ({bus.flush_busy, bus.flush_done} !== {1'b1, i == 7}) begin
            fails++;
            $display("FAIL ignore_sweep cnt=%0d got busy,done=%b exp=%b", i,
                     {bus.flush_busy, bus.flush_done}, {1'b1, i == 7});
         end
         next_cycle();
      end
      bus.flush_req = 1'b0;
      @(negedge clk);
      tests++;
      if ({bus.flush_busy, bus.arr_load} !== 2'b00) begin
         fails++;
         $display("FAIL ignore_no_restart got busy,load=%b exp=00", {bus.flush_busy, bus.arr_load});
      end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      bus.req0_valid = 1'b1; bus.req0_index = 3'd0; bus.req0_data = 1'b1;
      exp_q.push_back(wr_t'{idx: 3'd0, d: 1'b1});
      next_cycle();
      idle();
      bus.flush_req = 1'b1;
      next_cycle();
      bus.flush_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(wr_t'{idx: 3'(i), d: 1'b0});
         @(negedge clk);
         if (i < 5) next_cycle();
      end
      #1;
      rst = 1'b0;
      #1;
      tests++;
      if ({bus.arr_load, bus.flush_busy, bus.flush_done} !== 3'b000) begin
         fails++;
         $display("FAIL midreset_abort got load,busy,done=%b exp=000",
                  {bus.arr_load, bus.flush_busy, bus.flush_done});
      end
      rst = 1'b1;
      next_cycle();
      bus.req0_valid = 1'b1; bus.req0_index = 3'd2; bus.req0_data = 1'b1;
      bus.req1_valid = 1'b1; bus.req1_index = 3'd5; bus.req1_data = 1'b1;
      exp_q.push_back(wr_t'{idx: 3'd2, d: 1'b1});
      @(negedge clk);
      tests++;
      if ({bus.flush_busy, bus.req0_ready, bus.req1_ready} !== 3'b010) begin
         fails++;
         $display("FAIL midreset_pointer got busy,r0,r1=%b exp=010",
                  {bus.flush_busy, bus.req0_ready, bus.req1_ready});
      end
      next_cycle();
      idle();
      bus.rd_index = 3'd0;
      #1;
      tests++;
      if (bus.rd_data !== 1'b0) begin
         fails++;
         $display("FAIL midreset_kept_clear got=%b exp=0", bus.rd_data);
      end
      next_cycle();
   endtask

   task automatic test_sets6();
      int n       = 0;
      int done_at = -1;
      bus6.flush_req = 1'b1;
      next_cycle();
      bus6.flush_req = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus6.flush_busy) begin
            tests++;
            if (bus6.arr_windex !== 3'(n) || bus6.arr_datain !== 1'b0) begin
               fails++;
               $display("FAIL s6_windex got idx=%0d data=%0b exp idx=%0d data=0",
                        bus6.arr_windex, bus6.arr_datain, n);
            end
            if (bus6.flush_done) done_at = n;
            n++;
         end else if (n > 0) begin
            break;
         end
         next_cycle();
      end
      next_cycle();
      tests++;
      if (n !== 6) begin
         fails++;
         $display("FAIL s6_length got=%0d exp=6", n);
      end
      tests++;
      if (done_at !== 5) begin
         fails++;
         $display("FAIL s6_done got=%0d exp=5", done_at);
      end
   endtask

   initial begin
      idle();
      idle6();
      test_reset();
      test_single();
      test_round_robin();
      test_forward();
      test_flush();
      test_flush_ignore();
      test_reset_mid();
      test_sets6();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
